// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ack load/store with lane handling and wait states.
// Ports: i_clk, i_rst_n, i_mem_* request in; o_mem_ack/data/fault/busy out. Macro: DMEM_RANGE_CHECK_EN.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_req,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic [2:0]  i_funct3,
  input  logic        i_read_write,
  output logic        o_mem_ack,
  output logic [31:0] o_mem_data,
  output logic        o_fault,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [2:0]  f3_q, f3_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] widx;
  logic [31:0]       word;
  logic [31:0]       lshift;
  logic [15:0]       half;
  logic [31:0]       ld_val;
  logic [31:0]       st_val;
  logic              bad;
  logic              do_acc;
  logic              we;

  assign widx   = addr_q[ADDR_W+1:2];
  assign word   = mem[widx];
  assign lshift = word >> {addr_q[1:0], 3'b000};
  assign half   = addr_q[1] ? word[31:16] : word[15:0];

  // Legality and alignment of the latched access.
  always_comb begin
    bad = 1'b0;
    case (f3_q)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr_q[0];
      3'b010:  bad = |addr_q[1:0];
      3'b100:  bad = rw_q;
      3'b101:  bad = rw_q | addr_q[0];
      default: bad = 1'b1;
    endcase
`ifdef DMEM_RANGE_CHECK_EN
    if (|addr_q[31:ADDR_W+2]) bad = 1'b1;
`endif
  end

`ifndef DMEM_RANGE_CHECK_EN
  logic unused_addr;
  assign unused_addr = ^addr_q[31:ADDR_W+2];
`endif

  always_comb begin
    ld_val = 32'h0;
    case (f3_q)
      3'b000:  ld_val = {{24{lshift[7]}}, lshift[7:0]};
      3'b001:  ld_val = {{16{half[15]}}, half};
      3'b010:  ld_val = word;
      3'b100:  ld_val = {24'h0, lshift[7:0]};
      3'b101:  ld_val = {16'h0, half};
      default: ld_val = 32'h0;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep the old word.
  always_comb begin
    st_val = word;
    case (f3_q)
      3'b000: st_val[{addr_q[1:0], 3'b000} +: 8] = wdat_q[7:0];
      3'b001: begin
        if (addr_q[1]) st_val[31:16] = wdat_q[15:0];
        else           st_val[15:0]  = wdat_q[15:0];
      end
      3'b010:  st_val = wdat_q;
      default: st_val = word;
    endcase
  end

  assign do_acc = (state_q == BUSY) && i_mem_req && (cnt_q == 4'd0);
  assign we     = do_acc && rw_q && !bad;

  always_ff @(posedge i_clk) begin
    if (we) mem[widx] <= st_val;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    f3_d    = f3_q;
    rw_d    = rw_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (i_mem_req) begin
          addr_d  = i_mem_addr;
          wdat_d  = i_mem_data;
          f3_d    = i_funct3;
          rw_d    = i_read_write;
          cnt_d   = 4'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!i_mem_req) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (bad || rw_q) ? 32'h0 : ld_val;
          fault_d = bad;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d   = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        if (!i_mem_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdat_q  <= 32'h0;
      f3_q    <= 3'b000;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      f3_q    <= f3_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign o_mem_ack  = ack_q;
  assign o_mem_data = rdata_q;
  assign o_fault    = fault_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: two instances (0 and 3 wait states)
// checked against a byte-addressed reference memory.
module tb_dmem_ctrl;

  localparam int SPAN = 4096;

  logic        clk;
  logic        rst_n;
  logic        req  [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [2:0]  f3   [2];
  logic        rw   [2];
  logic        ack  [2];
  logic [31:0] rdat [2];
  logic        flt  [2];
  logic        busy [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb [2][SPAN];

  dmem_ctrl #(.WAIT_STATES(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(req[0]),
    .i_mem_addr(addr[0]), .i_mem_data(wd[0]), .i_funct3(f3[0]),
    .i_read_write(rw[0]), .o_mem_ack(ack[0]), .o_mem_data(rdat[0]),
    .o_fault(flt[0]), .o_busy(busy[0])
  );

  dmem_ctrl #(.WAIT_STATES(3)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(req[1]),
    .i_mem_addr(addr[1]), .i_mem_data(wd[1]), .i_funct3(f3[1]),
    .i_read_write(rw[1]), .o_mem_ack(ack[1]), .o_mem_data(rdat[1]),
    .o_fault(flt[1]), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte memory, size from funct3, alias modulo SPAN.
  task automatic model(input int k, input bit w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic f);
    int sz;
    bit legal;
    int off;
    logic [31:0] v;
    sz = (fn[1:0] == 2'd0) ? 1 : (fn[1:0] == 2'd1) ? 2 : 4;
    if (w) legal = (fn <= 3'd2);
    else   legal = (fn != 3'd3) && (fn != 3'd6) && (fn != 3'd7);
    f = !legal || ((a % sz) != 0);
`ifdef DMEM_RANGE_CHECK_EN
    if (a >= SPAN) f = 1'b1;
`endif
    r = 32'h0;
    if (!f) begin
      off = int'(a % SPAN);
      if (w) begin
        for (int i = 0; i < sz; i++) mb[k][off+i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mb[k][off+i]) << (8*i));
        if (!fn[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!fn[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        r = v;
      end
    end
  endtask

  task automatic acc(input int k, input bit w, input logic [2:0] fn,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic f);
    int n;
    bit got;
    logic [31:0] er;
    logic ef;
    @(negedge clk);
    rw[k] = w; f3[k] = fn; addr[k] = a; wd[k] = d; req[k] = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_sample", 32'(busy[k]), 32'd1);
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ack[k]) got = 1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(n), 32'((k == 0) ? 1 : 4));
    r = rdat[k];
    f = flt[k];
    model(k, w, fn, a, d, er, ef);
    chk("data_vs_model", r, er);
    chk("fault_vs_model", 32'(f), 32'(ef));
    @(posedge clk);
    #1;
    chk("ack_one_cycle", 32'(ack[k]), 32'd0);
    req[k] = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_drop", 32'(busy[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic f;
    logic [31:0] a;
    logic [31:0] exp10;
    bit sawack;
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; addr[k] = 0; wd[k] = 0; f3[k] = 0; rw[k] = 0;
    end
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack", 32'(ack[k]), 32'd0);
      chk("rst_data", rdat[k], 32'd0);
      chk("rst_fault", 32'(flt[k]), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        acc(k, 1, 3'b010, 32'(4*i), $urandom, r, f);

    acc(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, r, f);
    acc(0, 0, 3'b010, 32'h10, 32'h0, r, f);
    chk("lw_deadbeef", r, 32'hDEADBEEF);
    chk("lw_nofault", 32'(f), 32'd0);
    acc(0, 1, 3'b000, 32'h11, 32'h7F, r, f);
    acc(0, 0, 3'b000, 32'h11, 32'h0, r, f);
    chk("lb_7f", r, 32'h0000007F);
    acc(0, 0, 3'b100, 32'h11, 32'h0, r, f);
    chk("lbu_7f", r, 32'h0000007F);
    acc(0, 0, 3'b010, 32'h10, 32'h0, r, f);
    chk("lw_dead7fef", r, 32'hDEAD7FEF);
    acc(0, 1, 3'b000, 32'h13, 32'h80, r, f);
    acc(0, 0, 3'b000, 32'h13, 32'h0, r, f);
    chk("lb_sext", r, 32'hFFFFFF80);
    acc(0, 0, 3'b100, 32'h13, 32'h0, r, f);
    chk("lbu_zext", r, 32'h00000080);
    acc(0, 1, 3'b001, 32'h12, 32'h8001, r, f);
    acc(0, 0, 3'b001, 32'h12, 32'h0, r, f);
    chk("lh_sext", r, 32'hFFFF8001);
    acc(0, 0, 3'b101, 32'h12, 32'h0, r, f);
    chk("lhu_zext", r, 32'h00008001);
    acc(0, 0, 3'b010, 32'h10, 32'h0, r, f);
    chk("lw_80017fef", r, 32'h80017FEF);
    acc(0, 0, 3'b010, 32'h12, 32'h0, r, f);
    chk("lw_mis_fault", 32'(f), 32'd1);
    chk("lw_mis_data", r, 32'h0);
    acc(0, 1, 3'b001, 32'h13, 32'hFFFF, r, f);
    chk("sh_mis_fault", 32'(f), 32'd1);
    acc(0, 0, 3'b010, 32'h10, 32'h0, r, f);
    chk("lw_after_fault", r, 32'h80017FEF);

    acc(0, 1, 3'b010, 32'h1010, 32'h12345678, r, f);
`ifdef DMEM_RANGE_CHECK_EN
    chk("range_fault", 32'(f), 32'd1);
    exp10 = 32'h80017FEF;
`else
    chk("range_alias_nofault", 32'(f), 32'd0);
    exp10 = 32'h12345678;
`endif
    acc(0, 0, 3'b010, 32'h10, 32'h0, r, f);
    chk("range_word10", r, exp10);

    // Flush during wait states on the slow instance.
    @(negedge clk);
    rw[1] = 1; f3[1] = 3'b010; addr[1] = 32'h20; wd[1] = 32'hA5A5A5A5;
    req[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(busy[1]), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    sawack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack[1]) sawack = 1;
    end
    chk("flush_no_ack", 32'(sawack), 32'd0);
    chk("flush_idle", 32'(busy[1]), 32'd0);
    acc(1, 0, 3'b010, 32'h20, 32'h0, r, f);

    // Reset in the middle of a pending store.
    acc(1, 0, 3'b010, 32'h24, 32'h0, r, f);
    @(negedge clk);
    rw[1] = 1; f3[1] = 3'b010; addr[1] = 32'h24; wd[1] = ~r;
    req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack[1]), 32'd0);
    chk("midrst_data", rdat[1], 32'd0);
    chk("midrst_fault", 32'(flt[1]), 32'd0);
    chk("midrst_busy", 32'(busy[1]), 32'd0);
    @(negedge clk);
    req[1] = 1'b0;
    rst_n = 1'b1;
    acc(1, 0, 3'b010, 32'h24, 32'h0, r, f);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 60; i++) begin
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
        acc(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
            $urandom, r, f);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
